mem_stage_ctrl: RTL and testbench
=================================

// Module: mem_stage_ctrl
// PURPOSE
//  Memory-stage controller on the consumer side of the EX/MEM pipe register. It takes the
//  registered EX outputs and performs data-memory reads and writes over a req/ack handshake.
//  It stalls the front of the pipe while an access is outstanding.
//  It produces the registered fields that feed the MEM/WB pipe register.
//  Non-memory instructions pass through with 1-cycle latency.
// PARAMETERS
//  REGI_BITS   4   integer register index width
//  VECT_BITS   2   vector register index width
//  ELEM_SIZE   8   bits per element
//  VECT_SIZE   8   elements per data word; DW = ELEM_SIZE*VECT_SIZE
//  MEMO_LINES  64  data-memory depth; AW = $clog2(MEMO_LINES)
//  TIMEOUT_CYC 15  max cycles waiting for mem_ack_i before abort
// PORTS
//  clk_i             in   1          clock; rising edge
//  rst_i             in   1          synchronous, active-high reset
//  valid_i           in   1          EX/MEM holds a live instruction
//  flagMemRead_i     in   1          load
//  flagMemWrite_i    in   1          store
//  flagEnd_i         in   1          program end marker
//  flagNop_i         in   1          bubble
//  addr_i            in   AW         memory line address
//  int_rd_i          in   DW         ALU result / store data
//  intRegDest_i      in   REGI_BITS  int dest register
//  vecRegDest_i      in   VECT_BITS  vector dest register
//  memo_res_i        in   VECT_BITS  memory result select
//  writeResultInt_i  in   1          int writeback enable
//  writeResultV_i    in   1          vector writeback enable
//  stall_o           out  1          hold PC/IF/ID/EX and EX/MEM register
//  mem_req_o         out  1          memory request
//  mem_we_o          out  1          1 = write
//  mem_addr_o        out  AW         request address
//  mem_wdata_o       out  DW         write data
//  mem_ack_i         in   1          1-cycle completion pulse
//  mem_rdata_i       in   DW         read data; valid with mem_ack_i
//  wb_valid_o        out  1          result fields below valid this cycle
//  int_rd_o          out  DW         load data, or int_rd_i passthrough
//  intRegDest_o, vecRegDest_o, memo_res_o, writeResultInt_o, writeResultV_o, flagEnd_o, flagNop_o
//                    out  as inputs  registered copies to MEM/WB
//  err_o             out  1          sticky: timeout or illegal op
//  halted_o          out  1          sticky: flagEnd retired
// BEHAVIOUR
//  Reset: every output is 0 and the state is IDLE. Reset mid-ACCESS drops mem_req_o at the
//  same edge, and a late ack is ignored.
//  Definition: op = valid_i & !flagNop_i & !halted_o & (flagMemRead_i ^ flagMemWrite_i).
//  FSM IDLE:
//   - op: latch all input fields, addr_i and the int_rd_i write data.
//     Assert mem_req_o, mem_we_o and mem_addr_o/mem_wdata_o from the next cycle.
//     Go to ACCESS. wb_valid_o is 0 next cycle.
//   - Otherwise, if valid_i: register the fields to the outputs and set wb_valid_o=1 next cycle
//     (latency 1).
//   - Read & write both set: pass through with flagNop_o=1, writeResult*_o=0, err_o<=1.
//  FSM ACCESS:
//   - mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o stay stable until the ack.
//   - Ack at cycle N: at N+1, mem_req_o=0, wb_valid_o=1 and the state is IDLE.
//     int_rd_o = mem_rdata_i for a read, or the latched write data for a write.
//   - Timeout: no ack after TIMEOUT_CYC request cycles. Then drop the request, err_o<=1,
//     emit wb_valid_o=1 with flagNop_o=1 and writeResult*_o=0, and return to IDLE.
//  stall_o is combinational:
//   - (IDLE & op) | (ACCESS & !mem_ack_i & !timeout)
//   - So upstream advances in the ack cycle, and a back-to-back op is accepted at N+1.
//  halted_o <= 1 when a flagEnd_i instruction retires (wb_valid_o with flagEnd_o).
//  Afterwards valid_i is ignored: no requests, wb_valid_o stays 0.
//  wb_valid_o is a 1-cycle pulse per instruction. Outside a pulse, the result fields hold.
//  Timeout counter: width $clog2(TIMEOUT_CYC+1); cleared on entry to ACCESS; saturates.
// STRUCTURE
//  mem_pkg: typedef enum logic {IDLE, ACCESS} mem_state_t; constant DW/AW helper functions.
//  Sub-module mem_wdog: timeout counter with clear/enable inputs and an expired output.
// TESTING
//  1 ALU op, valid_i=1, int_rd_i=64'hA5, dest=3 -> next cycle wb_valid_o=1, int_rd_o=64'hA5,
//    intRegDest_o=3, stall_o never high.
//  2 Load addr 5, ack 3 cycles after req, rdata=64'h1234 -> stall_o high 3 cycles,
//    mem_we_o=0, mem_addr_o=5; int_rd_o=64'h1234 one cycle after ack.
//  3 Store addr 63, data 64'hFF, ack the same cycle req rises -> one-cycle stall,
//    mem_we_o=1, mem_wdata_o=64'hFF, wb_valid_o the next cycle.
//  4 Load with no ack -> req held exactly 15 cycles, then err_o=1, flagNop_o=1,
//    writeResultInt_o=0, state IDLE.
//  5 flagMemRead_i=flagMemWrite_i=1 -> no mem_req_o, err_o=1, flagNop_o=1.
//    Then rst_i mid-load -> req low next edge and all outputs 0.
//  6 flagEnd_i retires -> halted_o=1. A following load with valid_i=1 gives no mem_req_o and
//    no wb_valid_o.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and sizing helpers for the memory-stage controller.
//   mem_state_t : controller state (IDLE waits for work, ACCESS owns the bus)
//   calcDw      : data word width from element size and elements per word
//   calcAw      : line address width from memory depth
package mem_pkg;

  typedef enum logic {IDLE, ACCESS} mem_state_t;

  function automatic int calcDw(input int elemSize, input int vectSize);
    return elemSize * vectSize;
  endfunction

  function automatic int calcAw(input int lines);
    return $clog2(lines);
  endfunction

endpackage

// File: rtl/mem_wdog.sv
// Request watchdog for the memory stage.
//   clk_i     : clock, rising edge
//   rst_i     : synchronous active-high reset
//   clear_i   : force the count to zero (held while no access is outstanding)
//   enable_i  : count one more request cycle that went unanswered
//   expired_o : the current request cycle is the last one allowed (LIMIT-th)
module mem_wdog #(
  parameter  int LIMIT = 15,
  localparam int CW    = $clog2(LIMIT + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [CW-1:0] cntReg;

  // Count equals the number of request cycles already spent without an ack,
  // so it reads LIMIT-1 during the final permitted cycle. Saturates at LIMIT.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      cntReg <= '0;
    end else if (enable_i && (cntReg != CW'(LIMIT))) begin
      cntReg <= cntReg + 1'b1;
    end
  end

  assign expired_o = (cntReg >= CW'(LIMIT - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller between the EX/MEM and MEM/WB pipe registers.
// Loads/stores are issued over a req/ack handshake while the front of the pipe
// is stalled; everything else is passed through with one cycle of latency.
//   clk_i, rst_i                 : clock and synchronous active-high reset
//   valid_i, flag*_i, addr_i ... : registered EX outputs for the current instruction
//   stall_o                      : hold PC/IF/ID/EX and the EX/MEM register
//   mem_req_o/we/addr/wdata      : data-memory request, stable until acked
//   mem_ack_i, mem_rdata_i       : one-cycle completion pulse with read data
//   wb_valid_o + result fields   : one-cycle pulse per retired instruction to MEM/WB
//   err_o, halted_o              : sticky error (timeout/illegal op) and end-of-program
module mem_stage_ctrl
  import mem_pkg::*;
#(
  parameter  int REGI_BITS   = 4,
  parameter  int VECT_BITS   = 2,
  parameter  int ELEM_SIZE   = 8,
  parameter  int VECT_SIZE   = 8,
  parameter  int MEMO_LINES  = 64,
  parameter  int TIMEOUT_CYC = 15,
  localparam int DW          = calcDw(ELEM_SIZE, VECT_SIZE),
  localparam int AW          = calcAw(MEMO_LINES)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  input  logic                 flagMemRead_i,
  input  logic                 flagMemWrite_i,
  input  logic                 flagEnd_i,
  input  logic                 flagNop_i,
  input  logic [AW-1:0]        addr_i,
  input  logic [DW-1:0]        int_rd_i,
  input  logic [REGI_BITS-1:0] intRegDest_i,
  input  logic [VECT_BITS-1:0] vecRegDest_i,
  input  logic [VECT_BITS-1:0] memo_res_i,
  input  logic                 writeResultInt_i,
  input  logic                 writeResultV_i,
  output logic                 stall_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [AW-1:0]        mem_addr_o,
  output logic [DW-1:0]        mem_wdata_o,
  input  logic                 mem_ack_i,
  input  logic [DW-1:0]        mem_rdata_i,
  output logic                 wb_valid_o,
  output logic [DW-1:0]        int_rd_o,
  output logic [REGI_BITS-1:0] intRegDest_o,
  output logic [VECT_BITS-1:0] vecRegDest_o,
  output logic [VECT_BITS-1:0] memo_res_o,
  output logic                 writeResultInt_o,
  output logic                 writeResultV_o,
  output logic                 flagEnd_o,
  output logic                 flagNop_o,
  output logic                 err_o,
  output logic                 halted_o
);

  mem_state_t           stateReg;
  logic [REGI_BITS-1:0] intDestReg;
  logic [VECT_BITS-1:0] vecDestReg;
  logic [VECT_BITS-1:0] memoResReg;
  logic                 wrIntReg;
  logic                 wrVecReg;
  logic                 endReg;

  logic live;
  logic op;
  logic illegal;
  logic inAccess;
  logic expired;
  logic timeout;

  assign live     = valid_i && !flagNop_i && !halted_o;
  assign op       = live && (flagMemRead_i ^ flagMemWrite_i);
  assign illegal  = live && flagMemRead_i && flagMemWrite_i;
  assign inAccess = (stateReg == ACCESS);
  // An ack in the last permitted cycle still wins over the timeout.
  assign timeout  = inAccess && expired && !mem_ack_i;

  // Release upstream in the ack/timeout cycle so the next op lands right after.
  assign stall_o = (!inAccess && op) || (inAccess && !mem_ack_i && !timeout);

  mem_wdog #(.LIMIT(TIMEOUT_CYC)) uWdog (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (!inAccess),
    .enable_i  (inAccess && !mem_ack_i),
    .expired_o (expired)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stateReg         <= IDLE;
      mem_req_o        <= 1'b0;
      mem_we_o         <= 1'b0;
      mem_addr_o       <= '0;
      mem_wdata_o      <= '0;
      wb_valid_o       <= 1'b0;
      int_rd_o         <= '0;
      intRegDest_o     <= '0;
      vecRegDest_o     <= '0;
      memo_res_o       <= '0;
      writeResultInt_o <= 1'b0;
      writeResultV_o   <= 1'b0;
      flagEnd_o        <= 1'b0;
      flagNop_o        <= 1'b0;
      err_o            <= 1'b0;
      halted_o         <= 1'b0;
      intDestReg       <= '0;
      vecDestReg       <= '0;
      memoResReg       <= '0;
      wrIntReg         <= 1'b0;
      wrVecReg         <= 1'b0;
      endReg           <= 1'b0;
    end else begin
      wb_valid_o <= 1'b0;
      if (!inAccess) begin
        if (op) begin
          // The write data register doubles as the store-data latch.
          stateReg    <= ACCESS;
          mem_req_o   <= 1'b1;
          mem_we_o    <= flagMemWrite_i;
          mem_addr_o  <= addr_i;
          mem_wdata_o <= int_rd_i;
          intDestReg  <= intRegDest_i;
          vecDestReg  <= vecRegDest_i;
          memoResReg  <= memo_res_i;
          wrIntReg    <= writeResultInt_i;
          wrVecReg    <= writeResultV_i;
          endReg      <= flagEnd_i;
        end else if (valid_i && !halted_o) begin
          wb_valid_o       <= 1'b1;
          int_rd_o         <= int_rd_i;
          intRegDest_o     <= intRegDest_i;
          vecRegDest_o     <= vecRegDest_i;
          memo_res_o       <= memo_res_i;
          flagEnd_o        <= flagEnd_i;
          flagNop_o        <= flagNop_i || illegal;
          writeResultInt_o <= writeResultInt_i && !illegal;
          writeResultV_o   <= writeResultV_i && !illegal;
          if (illegal) err_o <= 1'b1;
          if (flagEnd_i) halted_o <= 1'b1;
        end
      end else if (mem_ack_i || timeout) begin
        stateReg         <= IDLE;
        mem_req_o        <= 1'b0;
        wb_valid_o       <= 1'b1;
        intRegDest_o     <= intDestReg;
        vecRegDest_o     <= vecDestReg;
        memo_res_o       <= memoResReg;
        flagEnd_o        <= endReg;
        flagNop_o        <= !mem_ack_i;
        writeResultInt_o <= wrIntReg && mem_ack_i;
        writeResultV_o   <= wrVecReg && mem_ack_i;
        // A timed-out access reports the latched operand word.
        int_rd_o         <= (mem_ack_i && !mem_we_o) ? mem_rdata_i : mem_wdata_o;
        if (!mem_ack_i) err_o <= 1'b1;
        if (endReg) halted_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;

  localparam int DW = 64;
  localparam int AW = 6;
  localparam int TO = 15;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic rst_i, valid_i, flagMemRead_i, flagMemWrite_i, flagEnd_i, flagNop_i;
  logic [AW-1:0] addr_i;
  logic [DW-1:0] int_rd_i;
  logic [3:0] intRegDest_i;
  logic [1:0] vecRegDest_i, memo_res_i;
  logic writeResultInt_i, writeResultV_i;
  logic stall_o, mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic mem_ack_i;
  logic [DW-1:0] mem_rdata_i;
  logic wb_valid_o;
  logic [DW-1:0] int_rd_o;
  logic [3:0] intRegDest_o;
  logic [1:0] vecRegDest_o, memo_res_o;
  logic writeResultInt_o, writeResultV_o, flagEnd_o, flagNop_o, err_o, halted_o;

  mem_stage_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i),
    .flagMemRead_i(flagMemRead_i), .flagMemWrite_i(flagMemWrite_i),
    .flagEnd_i(flagEnd_i), .flagNop_i(flagNop_i), .addr_i(addr_i),
    .int_rd_i(int_rd_i), .intRegDest_i(intRegDest_i), .vecRegDest_i(vecRegDest_i),
    .memo_res_i(memo_res_i), .writeResultInt_i(writeResultInt_i),
    .writeResultV_i(writeResultV_i), .stall_o(stall_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .wb_valid_o(wb_valid_o),
    .int_rd_o(int_rd_o), .intRegDest_o(intRegDest_o), .vecRegDest_o(vecRegDest_o),
    .memo_res_o(memo_res_o), .writeResultInt_o(writeResultInt_o),
    .writeResultV_o(writeResultV_o), .flagEnd_o(flagEnd_o), .flagNop_o(flagNop_o),
    .err_o(err_o), .halted_o(halted_o)
  );

  int checks = 0;
  int errors = 0;
  int stallCnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: one outstanding access at most, described by
  // what was accepted and how many request cycles it has waited so far.
  typedef struct {
    logic        rd;
    logic [63:0] data;
    logic [3:0]  idst;
    logic [1:0]  vdst, memo;
    logic        wi, wv, en;
  } txn_t;

  bit   mBusy;
  int   mWait;
  int   ackDelay;
  txn_t mTxn;

  logic        eReq, eWe, eWb, eWi, eWv, eEnd, eNop, eErr, eHalt;
  logic [5:0]  eAddr;
  logic [63:0] eWdata, eIntRd;
  bit          eIntKnown;
  logic [3:0]  eIdst;
  logic [1:0]  eVdst, eMemo;

  task automatic modelReset();
    mBusy = 0; mWait = 0;
    eReq = 0; eWe = 0; eWb = 0; eWi = 0; eWv = 0; eEnd = 0; eNop = 0; eErr = 0; eHalt = 0;
    eAddr = 0; eWdata = 0; eIntRd = 0; eIntKnown = 1; eIdst = 0; eVdst = 0; eMemo = 0;
  endtask

  task automatic retire(input logic end_flag);
    eWb = 1;
    if (end_flag) eHalt = 1;
  endtask

  // One clock: check the combinational stall, advance the model, then compare
  // every registered output just after the edge.
  task automatic step();
    logic op, illegal, expStall, lastCycle;
    #2;
    op = valid_i && !flagNop_i && !eHalt && (flagMemRead_i != flagMemWrite_i);
    illegal = valid_i && !flagNop_i && !eHalt && flagMemRead_i && flagMemWrite_i;
    lastCycle = (mWait + 1 == TO);
    expStall = mBusy ? (!mem_ack_i && !lastCycle) : op;
    chk("stall", stall_o, expStall);
    if (stall_o) stallCnt++;
    if (rst_i) begin
      modelReset();
    end else begin
      eWb = 0;
      if (mBusy) begin
        if (mem_ack_i || lastCycle) begin
          eReq = 0; mBusy = 0;
          eIdst = mTxn.idst; eVdst = mTxn.vdst; eMemo = mTxn.memo; eEnd = mTxn.en;
          if (mem_ack_i) begin
            eIntRd = mTxn.rd ? mem_rdata_i : mTxn.data; eIntKnown = 1;
            eNop = 0; eWi = mTxn.wi; eWv = mTxn.wv;
          end else begin
            eIntKnown = 0; eNop = 1; eWi = 0; eWv = 0; eErr = 1;
          end
          retire(mTxn.en);
        end else begin
          mWait++;
        end
      end else if (op) begin
        mBusy = 1; mWait = 0;
        ackDelay = ($urandom_range(0, 4) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 6);
        mTxn.rd = flagMemRead_i; mTxn.data = int_rd_i; mTxn.idst = intRegDest_i;
        mTxn.vdst = vecRegDest_i; mTxn.memo = memo_res_i; mTxn.wi = writeResultInt_i;
        mTxn.wv = writeResultV_i; mTxn.en = flagEnd_i;
        eReq = 1; eWe = flagMemWrite_i; eAddr = addr_i; eWdata = int_rd_i;
      end else if (valid_i && !eHalt) begin
        eIntRd = int_rd_i; eIntKnown = 1; eIdst = intRegDest_i; eVdst = vecRegDest_i;
        eMemo = memo_res_i; eEnd = flagEnd_i;
        eNop = flagNop_i || illegal;
        eWi = writeResultInt_i && !illegal;
        eWv = writeResultV_i && !illegal;
        if (illegal) eErr = 1;
        retire(flagEnd_i);
      end
    end
    @(posedge clk_i);
    #1;
    chk("mem_req", mem_req_o, eReq);
    if (eReq) begin
      chk("mem_we", mem_we_o, eWe);
      chk("mem_addr", mem_addr_o, eAddr);
      chk("mem_wdata", mem_wdata_o, eWdata);
    end
    chk("wb_valid", wb_valid_o, eWb);
    if (eIntKnown) chk("int_rd", int_rd_o, eIntRd);
    chk("intRegDest", intRegDest_o, eIdst);
    chk("vecRegDest", vecRegDest_o, eVdst);
    chk("memo_res", memo_res_o, eMemo);
    chk("writeResultInt", writeResultInt_o, eWi);
    chk("writeResultV", writeResultV_o, eWv);
    chk("flagEnd", flagEnd_o, eEnd);
    chk("flagNop", flagNop_o, eNop);
    chk("err", err_o, eErr);
    chk("halted", halted_o, eHalt);
  endtask

  task automatic idleInputs();
    valid_i = 0; flagMemRead_i = 0; flagMemWrite_i = 0; flagEnd_i = 0; flagNop_i = 0;
    addr_i = 0; int_rd_i = 0; intRegDest_i = 0; vecRegDest_i = 0; memo_res_i = 0;
    writeResultInt_i = 0; writeResultV_i = 0; mem_ack_i = 0; mem_rdata_i = 0;
  endtask

  initial begin
    int reqCnt;
    rst_i = 1;
    idleInputs();
    modelReset();
    ackDelay = 0;
    @(posedge clk_i); #1;
    step(); step();
    chk("rst_wb_valid", wb_valid_o, 0);
    chk("rst_req", mem_req_o, 0);
    chk("rst_int_rd", int_rd_o, 0);
    chk("rst_err", err_o, 0);
    rst_i = 0;
    step();

    // 1: ALU passthrough
    stallCnt = 0;
    valid_i = 1; int_rd_i = 64'hA5; intRegDest_i = 3; writeResultInt_i = 1;
    step();
    chk("t1_wb_valid", wb_valid_o, 1);
    chk("t1_int_rd", int_rd_o, 64'hA5);
    chk("t1_dest", intRegDest_o, 3);
    idleInputs();
    step();
    chk("t1_stall_count", stallCnt, 0);
    $display("txn t1 alu done");

    // 2: load, ack on the third request cycle
    stallCnt = 0;
    valid_i = 1; flagMemRead_i = 1; addr_i = 5; intRegDest_i = 7; writeResultInt_i = 1;
    step();
    idleInputs();
    chk("t2_req", mem_req_o, 1);
    chk("t2_we", mem_we_o, 0);
    chk("t2_addr", mem_addr_o, 5);
    step(); step();
    mem_ack_i = 1; mem_rdata_i = 64'h1234;
    step();
    mem_ack_i = 0;
    chk("t2_int_rd", int_rd_o, 64'h1234);
    chk("t2_wb_valid", wb_valid_o, 1);
    chk("t2_stall_count", stallCnt, 3);
    $display("txn t2 load done");

    // 3: store, acked as soon as the request rises
    stallCnt = 0;
    valid_i = 1; flagMemWrite_i = 1; addr_i = 63; int_rd_i = 64'hFF;
    step();
    idleInputs();
    chk("t3_we", mem_we_o, 1);
    chk("t3_wdata", mem_wdata_o, 64'hFF);
    chk("t3_addr", mem_addr_o, 63);
    mem_ack_i = 1;
    step();
    mem_ack_i = 0;
    chk("t3_wb_valid", wb_valid_o, 1);
    chk("t3_stall_count", stallCnt, 1);
    $display("txn t3 store done");

    // 4: load never acked
    valid_i = 1; flagMemRead_i = 1; addr_i = 7; writeResultInt_i = 1; intRegDest_i = 2;
    step();
    idleInputs();
    reqCnt = 0;
    for (int i = 0; i < 40 && mem_req_o; i++) begin
      reqCnt++;
      step();
    end
    chk("t4_req_cycles", reqCnt, 15);
    chk("t4_err", err_o, 1);
    chk("t4_nop", flagNop_o, 1);
    chk("t4_wrint", writeResultInt_o, 0);
    chk("t4_wb_valid", wb_valid_o, 1);
    $display("txn t4 timeout done");

    // 5: illegal op, then reset in the middle of a load
    rst_i = 1; step(); rst_i = 0;
    valid_i = 1; flagMemRead_i = 1; flagMemWrite_i = 1; writeResultInt_i = 1;
    step();
    idleInputs();
    chk("t5_req", mem_req_o, 0);
    chk("t5_err", err_o, 1);
    chk("t5_nop", flagNop_o, 1);
    valid_i = 1; flagMemRead_i = 1; addr_i = 9;
    step();
    idleInputs();
    step();
    rst_i = 1;
    step();
    rst_i = 0;
    chk("t5_rst_req", mem_req_o, 0);
    chk("t5_rst_err", err_o, 0);
    chk("t5_rst_nop", flagNop_o, 0);
    mem_ack_i = 1; mem_rdata_i = 64'hDEAD;
    step();
    mem_ack_i = 0;
    chk("t5_late_ack_wb", wb_valid_o, 0);
    $display("txn t5 illegal/reset done");

    // 6: program end then ignored load
    valid_i = 1; flagEnd_i = 1;
    step();
    idleInputs();
    chk("t6_halted", halted_o, 1);
    valid_i = 1; flagMemRead_i = 1; addr_i = 1;
    step(); step();
    chk("t6_req", mem_req_o, 0);
    chk("t6_wb", wb_valid_o, 0);
    idleInputs();
    rst_i = 1; step(); rst_i = 0;
    $display("txn t6 halt done");

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst_i = ($urandom_range(0, 199) == 0) || (eHalt && $urandom_range(0, 7) == 0);
      valid_i = ($urandom_range(0, 3) != 0);
      flagMemRead_i = ($urandom_range(0, 2) == 0);
      flagMemWrite_i = ($urandom_range(0, 3) == 0);
      flagNop_i = ($urandom_range(0, 7) == 0);
      flagEnd_i = ($urandom_range(0, 47) == 0);
      addr_i = AW'($urandom);
      int_rd_i = {$urandom, $urandom};
      intRegDest_i = 4'($urandom);
      vecRegDest_i = 2'($urandom);
      memo_res_i = 2'($urandom);
      writeResultInt_i = 1'($urandom);
      writeResultV_i = 1'($urandom);
      mem_ack_i = mBusy ? (mWait == ackDelay) : ($urandom_range(0, 15) == 0);
      mem_rdata_i = {$urandom, $urandom};
      step();
    end
    $display("txn random done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
